// File: rtl/i2c_stream_pkg.sv
// Shared definitions for the I2C stream master: command op codes, command and
// response field positions, and the controller state encoding.
package i2c_stream_pkg;

   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_STOP  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   localparam int CMD_OP_HI = 9;
   localparam int CMD_OP_LO = 8;
   localparam int CMD_NACK  = 10;
   localparam int RSP_ACK   = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_STOP,
      ST_BIT,
      ST_RESPOND
   } state_t;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit-period timer for the I2C master.
//   clk, rst : clock and synchronous active-high reset
//   run      : count while high; counter and quarter index clear while low
//   hold     : freeze the count (slave clock stretch)
//   q_tick   : one-cycle pulse on the last cycle of each quarter
//   q_idx    : current quarter q0..q3 within the bus phase
module i2c_quarter_timer #(
   parameter int CLK_DIV = 250,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       hold,
   output logic       q_tick,
   output logic [1:0] q_idx
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign q_tick = run && !hold && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt   <= '0;
         q_idx <= 2'd0;
      end else if (!hold) begin
         if (cnt == CNT_LAST) begin
            cnt   <= '0;
            q_idx <= q_idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_stream_master.sv
// Byte-level I2C master between 32-bit stb/ack command/response streams and
// open-drain SCL/SDA pins.
//   input_cmd/_stb/_ack    : command stream ([9:8] op, [7:0] data, [10] master nack)
//   output_rsp/_stb/_ack   : one response per command (read data or slave ack bit)
//   scl_i, sda_i           : sampled pin levels
//   scl_oe, sda_oe         : 1 pulls the line low, 0 releases it
//   busy                   : controller not idle
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a command, bus lines held at last levels
// ST_START   | four quarters generating a (repeated) START
// ST_STOP    | four quarters generating a STOP
// ST_BIT     | nine bit phases: 8 data bits MSB first, then ack bit
// ST_RESPOND | response presented, waiting for output_rsp_ack
module i2c_stream_master
   import i2c_stream_pkg::*;
#(
   parameter int CLK_DIV = 250,
   parameter int CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_cmd,
   input  logic        input_cmd_stb,
   output logic        input_cmd_ack,
   output logic [31:0] output_rsp,
   output logic        output_rsp_stb,
   input  logic        output_rsp_ack,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        scl_oe,
   output logic        sda_oe,
   output logic        busy
);

   state_t     state, state_nxt;
   logic       q_tick, run, hold;
   logic [1:0] q_idx;
   logic [3:0] bit_cnt;
   logic [7:0] tx_sr;
   logic [7:0] rsp_data;
   logic       is_read, mst_nack;
   logic       scl_hold, sda_hold;
   logic       bit_pull;
   logic       accept, rsp_xfer;
   logic [1:0] cmd_op;
   logic       unused_cmd_bits;

   assign cmd_op          = input_cmd[CMD_OP_HI:CMD_OP_LO];
   assign unused_cmd_bits = ^input_cmd[31:11];
   assign accept          = input_cmd_ack && input_cmd_stb;
   assign rsp_xfer        = output_rsp_stb && output_rsp_ack;
   assign run             = (state == ST_START) || (state == ST_STOP) || (state == ST_BIT);
   // Stretch: SCL released by us in q1 but still seen low means the slave holds it.
   assign hold            = (q_idx == 2'd1) && !scl_oe && !scl_i;
   assign busy            = (state != ST_IDLE);
   assign output_rsp      = {24'd0, rsp_data};

   i2c_quarter_timer #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .hold   (hold),
      .q_tick (q_tick),
      .q_idx  (q_idx)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_START: state_nxt = ST_START;
                  OP_STOP:  state_nxt = ST_STOP;
                  default:  state_nxt = ST_BIT;
               endcase
            end
         end
         ST_START, ST_STOP: begin
            if (q_tick && q_idx == 2'd3) state_nxt = ST_RESPOND;
         end
         ST_BIT: begin
            if (q_tick && q_idx == 2'd3 && bit_cnt == 4'd8) state_nxt = ST_RESPOND;
         end
         ST_RESPOND: begin
            if (rsp_xfer) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outside the active phases the lines keep whatever level the last phase left.
   always_comb begin
      if (bit_cnt == 4'd8) bit_pull = is_read && !mst_nack;
      else                 bit_pull = !is_read && !tx_sr[7];
      scl_oe = scl_hold;
      sda_oe = sda_hold;
      case (state)
         ST_START: begin
            case (q_idx)
               2'd0:    sda_oe = 1'b0;
               2'd1:    begin scl_oe = 1'b0; sda_oe = 1'b0; end
               2'd2:    begin scl_oe = 1'b0; sda_oe = 1'b1; end
               default: begin scl_oe = 1'b1; sda_oe = 1'b1; end
            endcase
         end
         ST_STOP: begin
            case (q_idx)
               2'd0:    sda_oe = 1'b1;
               2'd1:    begin scl_oe = 1'b0; sda_oe = 1'b1; end
               default: begin scl_oe = 1'b0; sda_oe = 1'b0; end
            endcase
         end
         ST_BIT: begin
            scl_oe = (q_idx == 2'd0) || (q_idx == 2'd3);
            sda_oe = bit_pull;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         input_cmd_ack  <= 1'b0;
         output_rsp_stb <= 1'b0;
         rsp_data       <= 8'd0;
         scl_hold       <= 1'b0;
         sda_hold       <= 1'b0;
         bit_cnt        <= 4'd0;
         tx_sr          <= 8'd0;
         is_read        <= 1'b0;
         mst_nack       <= 1'b0;
      end else begin
         state         <= state_nxt;
         scl_hold      <= scl_oe;
         sda_hold      <= sda_oe;
         input_cmd_ack <= (state == ST_IDLE) && !accept;

         if (accept) begin
            bit_cnt  <= 4'd0;
            tx_sr    <= input_cmd[7:0];
            is_read  <= (cmd_op == OP_READ);
            mst_nack <= input_cmd[CMD_NACK];
            rsp_data <= 8'd0;
         end

         if (state == ST_BIT && q_tick) begin
            if (q_idx == 2'd2) begin
               if (bit_cnt == 4'd8) begin
                  if (!is_read) rsp_data[RSP_ACK] <= sda_i;
               end else if (is_read) begin
                  rsp_data <= {rsp_data[6:0], sda_i};
               end
            end
            if (q_idx == 2'd3 && bit_cnt != 4'd8) begin
               bit_cnt <= bit_cnt + 4'd1;
               tx_sr   <= {tx_sr[6:0], 1'b0};
            end
         end

         if (rsp_xfer)                 output_rsp_stb <= 1'b0;
         else if (state == ST_RESPOND) output_rsp_stb <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2c_stream_master.sv
// Bench for i2c_stream_master with an open-drain slave model and a response
// scoreboard.
module tb_i2c_stream_master;

   localparam int CLK_DIV = 4;
   localparam int LAT_SS  = 4 * CLK_DIV + 1;
   localparam int LAT_RW  = 36 * CLK_DIV + 1;

   logic        clk, rst;
   logic [31:0] input_cmd;
   logic        input_cmd_stb, input_cmd_ack;
   logic [31:0] output_rsp;
   logic        output_rsp_stb, output_rsp_ack;
   logic        scl_i, sda_i, scl_oe, sda_oe, busy;
   logic        bfm_scl_pull, bfm_sda_pull;

   int          n_checks, n_errors;
   logic [31:0] exp_q[$];
   int          start_cnt;
   logic        prev_sda;
   int          pulses;
   logic [7:0]  seen_byte;
   logic        bit9_oe;
   logic        bfm_ok;

   assign scl_i = !(scl_oe || bfm_scl_pull);
   assign sda_i = !(sda_oe || bfm_sda_pull);

   i2c_stream_master #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .input_cmd      (input_cmd),
      .input_cmd_stb  (input_cmd_stb),
      .input_cmd_ack  (input_cmd_ack),
      .output_rsp     (output_rsp),
      .output_rsp_stb (output_rsp_stb),
      .output_rsp_ack (output_rsp_ack),
      .scl_i          (scl_i),
      .sda_i          (sda_i),
      .scl_oe         (scl_oe),
      .sda_oe         (sda_oe),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare on the cycle before a response transfer.
   always @(negedge clk) begin
      if (!rst && output_rsp_stb && output_rsp_ack) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("rsp", output_rsp, exp_q.pop_front());
      end
   end

   // START condition detector: SDA falling while SCL high.
   always @(negedge clk) begin
      if (scl_i && prev_sda && !sda_i) start_cnt++;
      prev_sda = sda_i;
   end

   task automatic wait_scl(input logic lvl, output logic ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (scl_i !== lvl) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic bfm_byte(input logic send, input logic [7:0] tx, input logic ack_it,
                           input int stretch_bit);
      logic ok;
      int   n;
      pulses    = 0;
      seen_byte = 8'd0;
      bfm_ok    = 1'b1;
      for (int b = 0; b < 9; b++) begin
         if (b < 8) bfm_sda_pull = send && !tx[7-b];
         else       bfm_sda_pull = ack_it;
         if (b == stretch_bit) begin
            bfm_scl_pull = 1'b1;
            n = 0;
            while (scl_oe !== 1'b0 && n < 3000) begin
               @(negedge clk);
               n++;
            end
            repeat (100) @(posedge clk);
            #1 bfm_scl_pull = 1'b0;
            @(negedge clk);
         end
         wait_scl(1'b1, ok);
         if (!ok) begin bfm_ok = 1'b0; break; end
         pulses++;
         if (b < 8) seen_byte = {seen_byte[6:0], sda_i};
         else       bit9_oe = sda_oe;
         wait_scl(1'b0, ok);
         if (!ok) begin bfm_ok = 1'b0; break; end
      end
      bfm_sda_pull = 1'b0;
      bfm_scl_pull = 1'b0;
   endtask

   task automatic do_cmd(input logic [31:0] cmd, input logic [31:0] exp, input int exp_lat,
                         input logic stall);
      int          k;
      logic        ok;
      logic [31:0] held;
      exp_q.push_back(exp);
      input_cmd     = cmd;
      input_cmd_stb = 1'b1;
      k = 0;
      while (!input_cmd_ack && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      check("accept", 32'(input_cmd_ack), 32'd1);
      @(posedge clk); #1;
      input_cmd_stb = 1'b0;
      check("ack_drop", 32'(input_cmd_ack), 32'd0);
      check("busy", 32'(busy), 32'd1);
      k = 0;
      while (!output_rsp_stb && k < 5000) begin
         @(posedge clk); #1;
         k++;
      end
      check("rsp_valid", 32'(output_rsp_stb), 32'd1);
      check("latency", 32'(k), 32'(exp_lat));
      if (stall) begin
         held = output_rsp;
         ok   = 1'b1;
         repeat (50) begin
            @(posedge clk); #1;
            if (output_rsp !== held || !output_rsp_stb || input_cmd_ack) ok = 1'b0;
         end
         check("stall_stable", 32'(ok), 32'd1);
      end
      output_rsp_ack = 1'b1;
      @(posedge clk); #1;
      output_rsp_ack = 1'b0;
      check("stb_drop", 32'(output_rsp_stb), 32'd0);
      check("idle", 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   k;
      n_checks = 0; n_errors = 0; start_cnt = 0; prev_sda = 1'b1;
      pulses = 0; seen_byte = 8'd0; bit9_oe = 1'b0; bfm_ok = 1'b1;
      bfm_scl_pull = 1'b0; bfm_sda_pull = 1'b0;
      output_rsp_ack = 1'b0;

      // Reset with a command already pending.
      rst = 1'b1;
      input_cmd = 32'h0000_0000;
      input_cmd_stb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_scl_oe", 32'(scl_oe), 32'd0);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_cmd_ack", 32'(input_cmd_ack), 32'd0);
      check("rst_rsp_stb", 32'(output_rsp_stb), 32'd0);
      check("rst_rsp", output_rsp, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ack_after_rst", 32'(input_cmd_ack), 32'd1);
      input_cmd_stb = 1'b0;

      // START then WRITE 0x96 acked by the slave.
      do_cmd(32'h0000_0000, 32'd0, LAT_SS, 1'b0);
      check("start_cond", 32'(start_cnt), 32'd1);
      fork
         do_cmd(32'h0000_0296, 32'd0, LAT_RW, 1'b0);
         bfm_byte(1'b0, 8'h00, 1'b1, -1);
      join
      check("bfm_ok_w96", 32'(bfm_ok), 32'd1);
      check("wr_bits_96", 32'(seen_byte), 32'h96);
      check("pulses_96", 32'(pulses), 32'd9);

      // WRITE 0x90 with no slave answering.
      fork
         do_cmd(32'h0000_0290, 32'd1, LAT_RW, 1'b0);
         bfm_byte(1'b0, 8'h00, 1'b0, -1);
      join
      check("wr_bits_90", 32'(seen_byte), 32'h90);
      check("pulses_90", 32'(pulses), 32'd9);

      // READs with master ACK and NACK.
      fork
         do_cmd(32'h0000_0300, 32'h0C, LAT_RW, 1'b0);
         bfm_byte(1'b1, 8'h0C, 1'b0, -1);
      join
      check("bit9_ack_oe", 32'(bit9_oe), 32'd1);
      fork
         do_cmd(32'h0000_0700, 32'hA5, LAT_RW, 1'b0);
         bfm_byte(1'b1, 8'hA5, 1'b0, -1);
      join
      check("bit9_nack_oe", 32'(bit9_oe), 32'd0);

      // READ with a 100-cycle clock stretch on bit 3.
      fork
         do_cmd(32'h0000_0300, 32'h5A, LAT_RW + 100, 1'b0);
         bfm_byte(1'b1, 8'h5A, 1'b0, 3);
      join
      check("bfm_ok_stretch", 32'(bfm_ok), 32'd1);

      // Response stalled for 50 cycles, then STOP.
      fork
         do_cmd(32'h0000_02C3, 32'd0, LAT_RW, 1'b1);
         bfm_byte(1'b0, 8'h00, 1'b1, -1);
      join
      check("wr_bits_c3", 32'(seen_byte), 32'hC3);
      do_cmd(32'h0000_0100, 32'd0, LAT_SS, 1'b0);

      // WRITE without START, a command waiting while busy, then reset mid-byte.
      input_cmd = 32'h0000_02A5;
      input_cmd_stb = 1'b1;
      k = 0;
      while (!input_cmd_ack && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      check("accept_mid", 32'(input_cmd_ack), 32'd1);
      @(posedge clk); #1;
      input_cmd = 32'h0000_0100;
      ok = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (input_cmd_ack || !busy) ok = 1'b0;
      end
      check("wait_while_busy", 32'(ok), 32'd1);
      input_cmd_stb = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_scl_oe", 32'(scl_oe), 32'd0);
      check("midrst_sda_oe", 32'(sda_oe), 32'd0);
      check("midrst_stb", 32'(output_rsp_stb), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_cmd(32'h0000_0100, 32'd0, LAT_SS, 1'b0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
